shift_reg_seq: RTL

- Command sequencer for the 4-bit universal shift register datapath.
- Accepts one command at a time over a valid/ready handshake: parallel load, or N-step shift-right, shift-left or rotate-right.
- Drives the register's select, parallel and serial-fill inputs one step per TICK strobe, holding the register (select 11) in all other cycles.
- Sits between the front-panel/CPU command source and the shift register. It replaces the register's private clock divider: the register and the divider run on CLK, and the divider supplies TICK.

---
 rtl/shift_reg_seq_pkg.sv | 36 +++
 rtl/shift_reg_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/shift_reg_seq_pkg.sv
// Shared types for the shift register command sequencer: op codes, select codes, FSM states.
package shift_reg_seq_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 3;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SEL_LOAD = 2'b00,
    SEL_SHR  = 2'b01,
    SEL_SHL  = 2'b10,
    SEL_HOLD = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

  // Rotate-right reuses the right-shift select; only the MSB fill differs.
  function automatic sel_e step_sel(input op_e op);
    case (op)
      OP_LOAD: step_sel = SEL_LOAD;
      OP_SHL:  step_sel = SEL_SHL;
      default: step_sel = SEL_SHR;
    endcase
  endfunction

endpackage

// File: rtl/shift_reg_seq.sv
// Command sequencer driving a 4-bit universal shift register, one step per TICK.
// Optional abort support is enabled with `define SHIFT_REG_SEQ_ABORT_EN.
module shift_reg_seq
  import shift_reg_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             TICK,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [CNT_W-1:0] CMD_COUNT,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic             CMD_FILL,
  input  logic [WIDTH-1:0] REG_Q,
`ifdef SHIFT_REG_SEQ_ABORT_EN
  input  logic             ABORT,
  output logic             ABORTED,
`endif
  output logic [1:0]       SR_SEL,
  output logic [WIDTH-1:0] SR_INP,
  output logic             SR_LEFT,
  output logic             SR_RIGHT,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] STEPS_LEFT
);

  state_e           r_state, w_state_nxt;
  op_e              r_op, w_op_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_fill, w_fill_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic [WIDTH-1:0] r_inp, w_inp_nxt;
  logic [CNT_W-1:0] r_steps, w_steps_nxt;
  logic             r_aborted, w_aborted_nxt;
  logic             w_unused_q;

  // Only the LSB of the register is needed (rotate feedback).
  assign w_unused_q = ^REG_Q[WIDTH-1:1];

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= IDLE;
      r_op      <= OP_LOAD;
      r_data    <= '0;
      r_fill    <= 1'b0;
      r_sel     <= SEL_HOLD;
      r_inp     <= '0;
      r_steps   <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_data    <= w_data_nxt;
      r_fill    <= w_fill_nxt;
      r_sel     <= w_sel_nxt;
      r_inp     <= w_inp_nxt;
      r_steps   <= w_steps_nxt;
      r_aborted <= w_aborted_nxt;
    end
  end

  // Next state; select defaults to hold so every step lasts exactly one cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_data_nxt    = r_data;
    w_fill_nxt    = r_fill;
    w_sel_nxt     = SEL_HOLD;
    w_inp_nxt     = r_inp;
    w_steps_nxt   = r_steps;
    w_aborted_nxt = r_aborted;
    case (r_state)
      IDLE: begin
        if (CMD_VALID) begin
          w_op_nxt      = op_e'(CMD_OP);
          w_data_nxt    = CMD_DATA;
          w_fill_nxt    = CMD_FILL;
          w_steps_nxt   = (op_e'(CMD_OP) == OP_LOAD) ? CNT_W'(1) : CMD_COUNT;
          w_aborted_nxt = 1'b0;
          w_state_nxt   = RUN;
        end
      end
      RUN: begin
`ifdef SHIFT_REG_SEQ_ABORT_EN
        if (ABORT) begin
          w_steps_nxt   = '0;
          w_aborted_nxt = 1'b1;
          w_state_nxt   = FIN;
        end else
`endif
        if (r_steps != '0) begin
          if (TICK) begin
            w_sel_nxt   = step_sel(r_op);
            w_inp_nxt   = r_data;
            w_steps_nxt = r_steps - CNT_W'(1);
          end
        end else if (r_sel == SEL_HOLD) begin
          // Last step's select has been sampled by the register; safe to finish.
          w_state_nxt = FIN;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    CMD_READY  = (r_state == IDLE);
    BUSY       = (r_state != IDLE);
    DONE       = (r_state == FIN);
    SR_SEL     = r_sel;
    SR_INP     = r_inp;
    STEPS_LEFT = r_steps;
    SR_RIGHT   = r_fill;
    SR_LEFT    = (r_op == OP_ROR) ? REG_Q[0] : r_fill;
`ifdef SHIFT_REG_SEQ_ABORT_EN
    ABORTED    = (r_state == FIN) && r_aborted;
`endif
  end

endmodule
